// File: rtl/mod_mul_vec.sv
// mod_mul_vec: LANES-wide 3-stage pipelined (a*b [+c]) mod 3329 with tag sideband and valid/ready; MAC via MOD_MUL_VEC_MAC_EN. Ports: clk, rst, op1_i, op2_i, [add_i], tag_i, valid_i, ready_o, result_o, tag_o, valid_o, ready_i, inflight_o, range_err_o
module mod_mul_vec #(
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0][11:0] op1_i,
  input  logic [LANES-1:0][11:0] op2_i,
`ifdef MOD_MUL_VEC_MAC_EN
  input  logic [LANES-1:0][11:0] add_i,
`endif
  input  logic [TAG_W-1:0]       tag_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [LANES-1:0][11:0] result_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [1:0]             inflight_o,
  output logic                   range_err_o
);
  localparam int Q = 3329;
`ifdef MOD_MUL_VEC_MAC_EN
  localparam int SW = 15;
`else
  localparam int SW = 14;
`endif
  function automatic logic [11:0] rt(input logic [3:0] k, input int w);
    return 12'((int'(k) * w) % Q);
  endfunction
  logic v1_q, v2_q, vo_q, err_q, en, acc;
  logic [LANES-1:0][11:0] a_q, b_q, r_q, r_d;
  logic [LANES-1:0][SW-1:0] s_q, s_d;
  logic [LANES-1:0] bad;
  logic [TAG_W-1:0] t1_q, t2_q, to_q;
`ifdef MOD_MUL_VEC_MAC_EN
  logic [LANES-1:0][11:0] c_q;
`endif
  assign en = !vo_q || ready_i;
  assign acc = valid_i && en;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [23:0] p;
    logic [13:0] f, c1;
    assign p = 24'(a_q[i]) * 24'(b_q[i]);
`ifdef MOD_MUL_VEC_MAC_EN
    assign bad[i] = op1_i[i] >= 12'(Q) || op2_i[i] >= 12'(Q) || add_i[i] >= 12'(Q);
    assign s_d[i] = SW'(p[11:0]) + SW'(rt(p[23:20], 3270)) + SW'(rt(p[19:16], 2285))
                  + SW'(rt(p[15:12], 767)) + SW'(c_q[i]);
`else
    assign bad[i] = op1_i[i] >= 12'(Q) || op2_i[i] >= 12'(Q);
    assign s_d[i] = SW'(p[11:0]) + SW'(rt(p[23:20], 3270)) + SW'(rt(p[19:16], 2285))
                  + SW'(rt(p[15:12], 767));
`endif
    // bits above 2^12 fold back as k*767 (2^12 mod Q)
    assign f = 14'(s_q[i][11:0]) + 14'(s_q[i][SW-1:12]) * 14'd767;
    assign c1 = f >= 14'(Q) ? f - 14'(Q) : f;
`ifdef MOD_MUL_VEC_MAC_EN
    assign r_d[i] = 12'(c1 >= 14'(Q) ? c1 - 14'(Q) : c1);
`else
    assign r_d[i] = 12'(c1);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1_q, v2_q, vo_q, err_q} <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      r_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      to_q <= '0;
`ifdef MOD_MUL_VEC_MAC_EN
      c_q <= '0;
`endif
    end else begin
      if (en) begin
        v1_q <= valid_i;
        a_q <= op1_i;
        b_q <= op2_i;
        t1_q <= tag_i;
`ifdef MOD_MUL_VEC_MAC_EN
        c_q <= add_i;
`endif
        v2_q <= v1_q;
        s_q <= s_d;
        t2_q <= t1_q;
        vo_q <= v2_q;
        r_q <= r_d;
        to_q <= t2_q;
      end
      err_q <= err_q | (acc && |bad);
    end
  end
  assign ready_o = en;
  assign valid_o = vo_q;
  assign result_o = r_q;
  assign tag_o = to_q;
  assign range_err_o = err_q;
  assign inflight_o = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, vo_q};
endmodule

// File: tb/tb_mod_mul_vec.sv
// tb_mod_mul_vec: directed bench with modular-arithmetic scoreboard for mod_mul_vec
module tb_mod_mul_vec;
  localparam int LANES = 2, TAG_W = 4, Q = 3329;
  logic clk = 0, rst = 1;
  logic [LANES-1:0][11:0] op1_i = '0, op2_i = '0, result_o;
`ifdef MOD_MUL_VEC_MAC_EN
  logic [LANES-1:0][11:0] add_i = '0;
`endif
  logic [TAG_W-1:0] tag_i = '0, tag_o;
  logic valid_i = 0, ready_i = 1, ready_o, valid_o, range_err_o;
  logic [1:0] inflight_o;
  int total = 0, bad = 0, retired = 0;
  always #5 clk = ~clk;
  mod_mul_vec #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i),
`ifdef MOD_MUL_VEC_MAC_EN
    .add_i(add_i),
`endif
    .tag_i(tag_i), .valid_i(valid_i), .ready_o(ready_o), .result_o(result_o),
    .tag_o(tag_o), .valid_o(valid_o), .ready_i(ready_i), .inflight_o(inflight_o),
    .range_err_o(range_err_o));
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [LANES-1:0][11:0] res;
  } exp_t;
  exp_t q[$];
  logic merr = 0, hold = 0;
  logic [TAG_W-1:0] ptag;
  logic [LANES-1:0][11:0] pres;
  function automatic int mm(input int a, input int b, input int c);
    return (a * b + c) % Q;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      merr = 0;
      hold = 0;
    end else begin
      exp_t e;
      int c;
      chk("ready_o", ready_o, !valid_o || ready_i);
      chk("inflight", inflight_o, q.size());
      chk("range_err", range_err_o, merr);
      if (hold) begin
        chk("hold_result", result_o, pres);
        chk("hold_tag", tag_o, ptag);
      end
      hold = valid_o && !ready_i;
      ptag = tag_o;
      pres = result_o;
      if (valid_i && ready_o) begin
        e.tag = tag_i;
        for (int l = 0; l < LANES; l++) begin
`ifdef MOD_MUL_VEC_MAC_EN
          c = int'(add_i[l]);
`else
          c = 0;
`endif
          e.res[l] = 12'(mm(int'(op1_i[l]), int'(op2_i[l]), c));
          if (op1_i[l] >= 12'(Q) || op2_i[l] >= 12'(Q) || c >= Q) merr = 1;
        end
        q.push_back(e);
      end
      if (valid_o && ready_i) begin
        retired++;
        if (q.size() == 0) chk("spurious_valid", valid_o, 1'b0);
        else begin
          e = q.pop_front();
          chk("tag", tag_o, e.tag);
          for (int l = 0; l < LANES; l++) chk("result", result_o[l], e.res[l]);
        end
      end
    end
  end
  task automatic send(input logic [11:0] a0, b0, a1, b1, c0, c1, input logic [TAG_W-1:0] t);
    int n = 0;
    logic acc;
    op1_i[0] = a0; op2_i[0] = b0; op1_i[1] = a1; op2_i[1] = b1;
`ifdef MOD_MUL_VEC_MAC_EN
    add_i[0] = c0; add_i[1] = c1;
`else
    if (c0 != 0 || c1 != 0) $display("note: addend ignored without MAC");
`endif
    tag_i = t;
    valid_i = 1;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    valid_i = 0;
    if (!acc) chk("accept_timeout", acc, 1'b1);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!valid_o) chk("valid_timeout", valid_o, 1'b1);
  endtask
  initial begin
    int n, r0, seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_range_err", range_err_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_ready_o", ready_o, 1);
    rst = 0;
    @(posedge clk);
    #1;
    send(3328, 3328, 3328, 3328, 0, 0, 4'd3);
    wait_valid(n);
    chk("latency", n + 1, 3);
    chk("neg1sq_l0", result_o[0], 1);
    chk("neg1sq_l1", result_o[1], 1);
    send(2, 1665, 0, 3328, 0, 0, 4'd4);
    wait_valid(n);
    chk("inv2_l0", result_o[0], 1);
    chk("zero_l1", result_o[1], 0);
    chk("no_range_err", range_err_o, 0);
    send(4095, 4095, 5, 7, 0, 0, 4'd6);
    wait_valid(n);
    chk("max_l0", result_o[0], 852);
    chk("small_l1", result_o[1], 35);
    chk("range_err_set", range_err_o, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("range_err_sticky", range_err_o, 1);
`ifdef MOD_MUL_VEC_MAC_EN
    send(3328, 3328, 4095, 4095, 3328, 4095, 4'd7);
    wait_valid(n);
    chk("mac_l0", result_o[0], 0);
    chk("mac_l1", result_o[1], 1618);
`endif
    for (int i = 0; i < 12; i++)
      send(12'((i * 397 + 11) % 4096), 12'((i * 1021 + 3000) % 4096),
           12'((i * 2333) % 3329), 12'(3328 - i * 97), 12'(i * 300), 12'(4095 - i), 4'(i));
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("clr_range_err", range_err_o, 0);
    rst = 0;
    r0 = retired;
    fork
      for (int t = 1; t <= 5; t++) send(12'(100 + t), 12'(200 + t), 12'(300 + t), 12'(17 * t), 0, 0, 4'(t));
      begin
        wait_valid(n);
        ready_i = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_ready_o", ready_o, 0);
        chk("stall_inflight", inflight_o, 3);
        chk("stall_tag", tag_o, 1);
        chk("stall_result", result_o[0], mm(101, 201, 0));
        ready_i = 1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("stream_count", retired - r0, 5);
    ready_i = 0;
    send(4000, 1, 2, 3, 0, 0, 4'd9);
    send(5, 6, 7, 8, 0, 0, 4'd10);
    send(9, 10, 11, 12, 0, 0, 4'd11);
    chk("full_inflight", inflight_o, 3);
    chk("full_range_err", range_err_o, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_inflight", inflight_o, 0);
    chk("mid_rst_range_err", range_err_o, 0);
    chk("mid_rst_ready_o", ready_o, 1);
    rst = 0;
    ready_i = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    chk("stale_beat", seen, 0);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_mul_vec.md
MOD_MUL_VEC -- requirements
Module: mod_mul_vec

Interface
REQ-001 Parameter LANES, default 2, number of independent modular-multiplier lanes (1..8).
REQ-002 Parameter TAG_W, default 4, width of a sideband tag carried alongside each beat.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 op1_i  input  LANES x 12 (coeff_t)  first operand per lane.
REQ-006 op2_i  input  LANES x 12 (coeff_t)  second operand per lane.
REQ-007 add_i  input  LANES x 12 (coeff_t)  addend per lane; port present only with MOD_MUL_VEC_MAC_EN.
REQ-008 tag_i  input  TAG_W  sideband tag; returned unchanged with the beat.
REQ-009 valid_i  input  1  input beat valid.
REQ-010 ready_o  output  1  block accepts a beat this cycle.
REQ-011 result_o  output  LANES x 12  per-lane result, 0..3328.
REQ-012 tag_o  output  TAG_W  tag of the beat on result_o.
REQ-013 valid_o  output  1  output beat valid.
REQ-014 ready_i  input  1  downstream accepts the output beat.
REQ-015 inflight_o  output  2  number of valid beats held in the pipeline (0..3).
REQ-016 range_err_o  output  1  sticky flag, any accepted operand or addend >= 3329.

Function
REQ-017 Result per lane SHALL be (op1*op2) mod 3329, or (op1*op2 + add) mod 3329 with MAC enabled, correct for any 12-bit input value including 3329..4095.
REQ-018 Three register stages (input, post-stage-1-reduction, output); latency SHALL be exactly 3 cycles from accepted beat to valid_o when never stalled.
REQ-019 Beat accepted when valid_i && ready_o; output beat retired when valid_o && ready_i.
REQ-020 Global advance enable en = !valid_o || ready_i; ready_o SHALL equal en; all stages hold when en is low.
REQ-021 Bubbles are not collapsed; a stalled pipeline holds empty and full stages alike.
REQ-022 Throughput SHALL be one beat per cycle while ready_i stays high.
REQ-023 result_o and tag_o SHALL remain stable while valid_o && !ready_i.
REQ-024 Stage 1: 24-bit product split into [23:20],[19:16],[15:12],[11:0]; three 16-entry residue tables (weights 2^20, 2^16, 2^12 mod 3329); partial sum 14 bits (max 13751).
REQ-025 With MAC, addend joins stage-1 sum; sum widens to 15 bits (max 17846).
REQ-026 Stage 2: top bits (2 bits, or 3 with MAC) folded via k*767 table into lower 12 bits; then conditional subtraction of Q once (no MAC) or up to twice (MAC, sum max 7163).
REQ-027 inflight_o SHALL count valid stage bits: +1 on accept, -1 on retire, unchanged when both occur in one cycle.
REQ-028 range_err_o SHALL set one cycle after accepting a beat with any lane operand >= 3329; it clears only on reset.
REQ-029 Beats offered while ready_o is low SHALL be ignored and not counted.

Reset
REQ-030 On rst, all stage valid bits, valid_o, inflight_o and range_err_o SHALL be 0; result_o and tag_o SHALL be 0.
REQ-031 ready_o SHALL be 1 during and after reset (valid_o is 0).
REQ-032 Reset mid-operation SHALL discard all in-flight beats; no stale beat appears after reset.

Configuration
REQ-033 Macro MOD_MUL_VEC_MAC_EN: defined -> add_i port, 15-bit stage-1 sum, 3-bit fold and double correction present; undefined -> add_i absent, pure multiply, single correction.

Verification
REQ-034 LANES=2, op1=op2=3328 both lanes, ready_i=1 -> result 1 both lanes, valid_o exactly 3 cycles after accept.
REQ-035 Lane0 2*1665, lane1 0*3328 -> results 1 and 0; range_err_o stays 0.
REQ-036 Lane0 4095*4095 -> result 852; range_err_o goes 1 and stays 1 until rst.
REQ-037 MAC build: 3328*3328 + add 3328 -> 0; 4095*4095 + 4095 -> 852+766 = 1618.
REQ-038 Stream 5 tagged beats (tags 1..5), hold ready_i=0 after first output -> ready_o 0, inflight_o 3, result_o/tag_o held at tag 1; release -> tags 1..5 delivered in order, none lost or duplicated.
REQ-039 Assert rst with inflight_o=3 -> next cycle valid_o=0, inflight_o=0, range_err_o=0, ready_o=1; no old tag emerges afterwards.
